// File: rtl/fsk_zc_if.sv
// Sample stream in, recovered symbols and link status out, for the FSK zero-crossing demodulator.
interface fsk_zc_if #(
   parameter int W     = 8,
   parameter int CNT_W = 10
) ();
   logic signed [W-1:0] sample_in;
   logic                sample_valid;
   logic                bit_out;
   logic                bit_valid;
   logic [CNT_W-1:0]    period_out;
   logic                locked;
   logic                los;

   modport master (
      output sample_in, sample_valid,
      input  bit_out, bit_valid, period_out, locked, los
   );

   modport slave (
      input  sample_in, sample_valid,
      output bit_out, bit_valid, period_out, locked, los
   );
endinterface

// File: rtl/fsk_zc_demod.sv
// FSK demodulator: hysteretic rising zero-crossing detector, period counter, threshold slicer
// and lock / loss-of-signal tracking.
module fsk_zc_demod #(
   parameter int W          = 8,
   parameter int CNT_W      = 10,
   parameter int HYST       = 4,
   parameter int PERIOD_THR = 48,
   parameter int LOCK_CNT   = 2,
   parameter int TIMEOUT    = 1023
) (
   input logic     clk,
   input logic     rst,
   fsk_zc_if.slave bus
);
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam logic signed [W-1:0] HystPos = W'(HYST);
   localparam logic signed [W-1:0] HystNeg = W'(-HYST);

   typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic [LW-1:0]    lock_q, lock_d;

   // First stage: measurement taken on the crossing edge, published one edge later.
   logic             meas_q, meas_d;
   logic             sym_q, sym_d;
   logic [CNT_W-1:0] meas_per_q, meas_per_d;

   logic             bit_out_q, bit_valid_q;
   logic [CNT_W-1:0] period_q;

   logic signed [W-1:0] s;
   logic                is_neg, is_pos, crossing;
   logic [CNT_W-1:0]    cnt_inc;
   logic [LW-1:0]       lock_inc;

   assign s        = bus.sample_in;
   assign is_neg   = s <= HystNeg;
   assign is_pos   = s >= HystPos;
   assign crossing = armed_q && is_pos;
   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign lock_inc = lock_q + LW'(1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      armed_d    = armed_q;
      lock_d     = lock_q;
      meas_d     = 1'b0;
      sym_d      = 1'b0;
      meas_per_d = meas_per_q;
      if (bus.sample_valid) begin
         if (crossing) begin
            armed_d = 1'b0;
         end else if (is_neg) begin
            armed_d = 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (crossing) begin
                  state_d = StAcquire;
                  lock_d  = '0;
               end
            end
            StAcquire, StLocked: begin
               if (crossing) begin
                  cnt_d      = '0;
                  meas_d     = 1'b1;
                  meas_per_d = cnt_inc;
                  if (state_q == StLocked) begin
                     sym_d = 1'b1;
                  end else if (lock_inc == LW'(LOCK_CNT)) begin
                     state_d = StLocked;
                     lock_d  = '0;
                  end else begin
                     lock_d = lock_inc;
                  end
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // A crossing on this same sample wins, so cnt never wraps.
                  state_d = StIdle;
                  cnt_d   = '0;
                  lock_d  = '0;
                  armed_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         lock_q      <= '0;
         meas_q      <= 1'b0;
         sym_q       <= 1'b0;
         meas_per_q  <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         period_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         lock_q      <= lock_d;
         meas_q      <= meas_d;
         sym_q       <= sym_d;
         meas_per_q  <= meas_per_d;
         bit_valid_q <= sym_q;
         if (meas_q) begin
            period_q <= meas_per_q;
         end
         if (sym_q) begin
            bit_out_q <= meas_per_q < CNT_W'(PERIOD_THR);
         end
      end
   end

   assign bus.bit_out    = bit_out_q;
   assign bus.bit_valid  = bit_valid_q;
   assign bus.period_out = period_q;
   assign bus.locked     = (state_q == StLocked);
   assign bus.los        = (state_q == StIdle);
endmodule

// File: tb/tb_fsk_zc_demod.sv
// Directed bench for fsk_zc_demod: square waves of known period, noise, gapped valid,
// timeout and reset, with hand-computed expectations.
module tb_fsk_zc_demod;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   fsk_zc_if #(.W(8), .CNT_W(10)) bus ();

   fsk_zc_demod #(
      .W(8), .CNT_W(10), .HYST(4), .PERIOD_THR(48), .LOCK_CNT(2), .TIMEOUT(1023)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int s, input logic v);
      bus.sample_in    = 8'(s);
      bus.sample_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int s, input int n);
      repeat (n) step(s, 1'b1);
   endtask

   // Valid sample followed by an invalid cycle carrying an opposite-polarity decoy.
   task automatic run_alt(input int s, input int junk, input int n);
      repeat (n) begin
         step(s, 1'b1);
         step(junk, 1'b0);
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      step(0, 1'b0);
      step(0, 1'b0);
      chk("rst_bit_out", bus.bit_out, 0);
      chk("rst_bit_valid", bus.bit_valid, 0);
      chk("rst_period", bus.period_out, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_los", bus.los, 1);
      rst = 1'b0;

      // 32-sample square wave: acquire and lock
      run(-100, 16); run(100, 1);
      chk("c1_los", bus.los, 0);
      chk("c1_locked", bus.locked, 0);
      run(100, 15); run(-100, 16); run(100, 1);
      chk("c2_locked", bus.locked, 0);
      run(100, 15); run(-100, 16); run(100, 1);
      chk("c3_locked", bus.locked, 1);
      run(100, 1);
      chk("c3_period", bus.period_out, 32);
      chk("c3_no_sym", bus.bit_valid, 0);
      run(100, 14); run(-100, 16); run(100, 1);
      chk("c4_latency", bus.bit_valid, 0);
      run(100, 1);
      chk("c4_bv", bus.bit_valid, 1);
      chk("c4_bit", bus.bit_out, 1);
      chk("c4_period", bus.period_out, 32);
      run(100, 1);
      chk("c4_bv_clr", bus.bit_valid, 0);

      // switch to 64-sample period; first period is 14+32+1+... = 48 exactly
      run(100, 13); run(-100, 32); run(100, 1);
      run(100, 1);
      chk("mix_period", bus.period_out, 48);
      chk("mix_bit48", bus.bit_out, 0);
      chk("mix_bv", bus.bit_valid, 1);
      run(100, 30); run(-100, 32); run(100, 1);
      run(100, 1);
      chk("p64_period", bus.period_out, 64);
      chk("p64_bit", bus.bit_out, 0);
      chk("p64_locked", bus.locked, 1);

      // period 47 -> bit 1
      run(100, 14); run(-100, 31); run(100, 1);
      run(100, 1);
      chk("p47_period", bus.period_out, 47);
      chk("p47_bit", bus.bit_out, 1);

      // sample_valid low on alternate cycles, 32-sample period
      run_alt(100, -100, 14); run_alt(-100, 100, 16);
      step(100, 1'b1);
      step(-100, 1'b0);
      chk("gap_bv", bus.bit_valid, 1);
      chk("gap_period", bus.period_out, 32);
      chk("gap_bit", bus.bit_out, 1);
      step(-100, 1'b0);
      chk("gap_bv_pulse", bus.bit_valid, 0);

      // synchronous reset while locked mid-period
      rst = 1'b1;
      step(100, 1'b1);
      rst = 1'b0;
      chk("mrst_locked", bus.locked, 0);
      chk("mrst_los", bus.los, 1);
      chk("mrst_period", bus.period_out, 0);
      chk("mrst_bit", bus.bit_out, 0);
      chk("mrst_bv", bus.bit_valid, 0);
      run(-100, 16); run(100, 1);
      chk("rl1_los", bus.los, 0);
      run(100, 15); run(-100, 16); run(100, 1);
      chk("rl2_locked", bus.locked, 0);
      run(100, 15); run(-100, 16); run(100, 1);
      chk("rl3_locked", bus.locked, 1);

      // sub-hysteresis noise: timeout on the 1023rd sample after the last crossing
      for (int i = 0; i < 511; i++) begin
         run(-3, 1); run(3, 1);
      end
      chk("pre_to_locked", bus.locked, 1);
      chk("pre_to_los", bus.los, 0);
      run(-3, 1);
      chk("to_locked", bus.locked, 0);
      chk("to_los", bus.los, 1);
      chk("to_period_hold", bus.period_out, 32);
      chk("to_bit_hold", bus.bit_out, 0);
      for (int i = 0; i < 20; i++) begin
         run(3, 1); run(-3, 1);
      end
      chk("noise_idle_los", bus.los, 1);

      // relock, then a crossing exactly on sample 1023
      run(-100, 16); run(100, 1);
      run(100, 15); run(-100, 16); run(100, 1);
      run(100, 15); run(-100, 16); run(100, 1);
      chk("max_pre_locked", bus.locked, 1);
      run(3, 1006); run(-100, 16); run(100, 1);
      chk("max_los", bus.los, 0);
      chk("max_locked", bus.locked, 1);
      run(100, 1);
      chk("max_period", bus.period_out, 1023);
      chk("max_bv", bus.bit_valid, 1);
      chk("max_bit", bus.bit_out, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
